cell_sel_enc: RTL and testbench

- Player-side encoder that produces the 5-bit cell index consumed by the minesweeper datapath's load/decode path.
- Converts raw directional and select buttons into a wrapping cursor on the 5x5 board.
- Presents the selected index to the game controller through a valid/ack handshake.
- Rejects selections of cells the datapath already reports as cleared.

---
 rtl/minesweeper_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/cell_sel_enc.sv | 187 ++++++++++++++++++
 tb/tb_cell_sel_enc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared board definitions for the minesweeper datapath and the player-side
// cell selector: grid geometry, index/map types and the selector state enum.
package minesweeper_pkg;

    localparam int GRID_W  = 5;
    localparam int GRID_H  = 5;
    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IDX_W   = 5;

    typedef logic [IDX_W-1:0]   cell_idx_t;
    typedef logic [N_CELLS-1:0] cell_map_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sel_state_t;

    // Row-major cell index: row * GRID_W + col.
    function automatic cell_idx_t cell_index(input logic [2:0] row, input logic [2:0] col);
        return cell_idx_t'(int'(row) * GRID_W + int'(col));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stable-sample debouncer and a
// one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_ff1_reg;
    logic             sync_ff2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             rise_reg;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1_reg <= 1'b0;
            sync_ff2_reg <= 1'b0;
        end else begin
            sync_ff1_reg <= btn_raw;
            sync_ff2_reg <= sync_ff1_reg;
        end
    end

    // Flip the level only after DEB_CYCLES consecutive samples disagree with it;
    // the rise pulse is registered alongside the level flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            if (sync_ff2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= sync_ff2_reg;
                rise_reg  <= sync_ff2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/cell_sel_enc.sv
// Player-side cell selector: debounced buttons drive a wrapping cursor on the
// board, and select presents the cursor's cell index to the game controller
// through a valid/ack handshake, refusing busy periods and cleared cells.
// Optional build macro CELL_SEL_REPEAT_EN adds auto-repeat on held directions.
module cell_sel_enc
    import minesweeper_pkg::*;
#(
    parameter int DEB_CYCLES = 4
`ifdef CELL_SEL_REPEAT_EN
    , parameter int REPEAT_CYCLES = 16
`endif
) (
    input  logic             clka,
    input  logic             restart_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_sel,
    input  logic [N_CELLS-1:0] cleared,
    input  logic             busy,
    input  logic             sel_ack,
    output logic [IDX_W-1:0] data,
    output logic             sel_valid,
    output logic             sel_reject,
    output logic [2:0]       cursor_row,
    output logic [2:0]       cursor_col
);

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_SEL   = 4;

    localparam logic [2:0] ROW_LAST = 3'(GRID_H - 1);
    localparam logic [2:0] COL_LAST = 3'(GRID_W - 1);

    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_evt;
    logic [3:0] move_evt;
    logic       unused_level;

    logic [2:0] row_reg;
    logic [2:0] col_reg;
    logic [2:0] row_next;
    logic [2:0] col_next;
    cell_idx_t  cur_idx;

    sel_state_t state_reg;
    cell_idx_t  data_reg;
    logic       valid_reg;
    logic       reject_reg;

    assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (clka),
                .rst_n   (restart_n),
                .btn_raw (btn_raw[gi]),
                .level   (btn_level[gi]),
                .rise    (btn_evt[gi])
            );
        end
    endgenerate

    // Levels only matter to the auto-repeat logic (and never for select).
    assign unused_level = ^btn_level;

`ifdef CELL_SEL_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [3:0] rep_evt;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rep
            logic [REP_W-1:0] rep_cnt_reg;
            logic             rep_pulse_reg;

            // Restart the hold timer on the initial edge, on release, or while the
            // opposite direction is also held; fire every REPEAT_CYCLES otherwise.
            always_ff @(posedge clka or negedge restart_n) begin
                if (!restart_n) begin
                    rep_cnt_reg   <= '0;
                    rep_pulse_reg <= 1'b0;
                end else if (!btn_level[gi] || btn_level[gi ^ 1] || btn_evt[gi]) begin
                    rep_cnt_reg   <= '0;
                    rep_pulse_reg <= 1'b0;
                end else if (rep_cnt_reg == REP_LAST) begin
                    rep_cnt_reg   <= '0;
                    rep_pulse_reg <= 1'b1;
                end else begin
                    rep_cnt_reg   <= rep_cnt_reg + 1'b1;
                    rep_pulse_reg <= 1'b0;
                end
            end

            assign rep_evt[gi] = rep_pulse_reg;
        end
    endgenerate

    assign move_evt = btn_evt[3:0] | rep_evt;
`else
    assign move_evt = btn_evt[3:0];
`endif

    // Next cursor position: opposing events cancel, each axis wraps independently.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (move_evt[B_UP] && !move_evt[B_DOWN]) begin
            row_next = (row_reg == 3'd0) ? ROW_LAST : row_reg - 3'd1;
        end else if (move_evt[B_DOWN] && !move_evt[B_UP]) begin
            row_next = (row_reg == ROW_LAST) ? 3'd0 : row_reg + 3'd1;
        end
        if (move_evt[B_LEFT] && !move_evt[B_RIGHT]) begin
            col_next = (col_reg == 3'd0) ? COL_LAST : col_reg - 3'd1;
        end else if (move_evt[B_RIGHT] && !move_evt[B_LEFT]) begin
            col_next = (col_reg == COL_LAST) ? 3'd0 : col_reg + 3'd1;
        end
    end

    // Cursor register; moves are accepted in every selector state.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            row_reg <= 3'd0;
            col_reg <= 3'd0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    // Index of the current (pre-move) cursor cell.
    assign cur_idx = cell_index(row_reg, col_reg);

    // Select handshake: latch the index on an accepted select and hold it until ack.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            reject_reg <= 1'b0;
        end else begin
            reject_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_evt[B_SEL]) begin
                        if (busy || cleared[cur_idx]) begin
                            reject_reg <= 1'b1;
                        end else begin
                            data_reg  <= cur_idx;
                            valid_reg <= 1'b1;
                            state_reg <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (btn_evt[B_SEL]) begin
                        reject_reg <= 1'b1;
                    end
                    if (sel_ack) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data       = data_reg;
    assign sel_valid  = valid_reg;
    assign sel_reject = reject_reg;
    assign cursor_row = row_reg;
    assign cursor_col = col_reg;

endmodule

// File: tb/tb_cell_sel_enc.sv
// Directed bench for cell_sel_enc: reset, cursor wrap, select handshake,
// reject cases, debounce filtering, auto-repeat hold and async reset mid-request.
module tb_cell_sel_enc;

    logic        clka = 1'b0;
    logic        restart_n = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_sel = 1'b0;
    logic [24:0] cleared = '0;
    logic        busy = 1'b0;
    logic        sel_ack = 1'b0;
    logic [4:0]  data;
    logic        sel_valid;
    logic        sel_reject;
    logic [2:0]  cursor_row;
    logic [2:0]  cursor_col;

    int tests = 0;
    int fails = 0;
    int rej_cnt = 0;
    int val_cnt = 0;

    localparam logic [4:0] M_UP    = 5'b00001;
    localparam logic [4:0] M_DOWN  = 5'b00010;
    localparam logic [4:0] M_LEFT  = 5'b00100;
    localparam logic [4:0] M_RIGHT = 5'b01000;
    localparam logic [4:0] M_SEL   = 5'b10000;

`ifdef CELL_SEL_REPEAT_EN
    localparam int HOLD_COL = 4;
`else
    localparam int HOLD_COL = 1;
`endif

    cell_sel_enc dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_sel    (btn_sel),
        .cleared    (cleared),
        .busy       (busy),
        .sel_ack    (sel_ack),
        .data       (data),
        .sel_valid  (sel_valid),
        .sel_reject (sel_reject),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock, then sample outputs 1 time unit after the edge.
    task automatic tick_sample();
        @(posedge clka);
        #1;
        if (sel_reject === 1'b1) rej_cnt++;
        if (sel_valid === 1'b1) val_cnt++;
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_sel, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    // Hold a button pattern for 'hold' cycles, release, and let it settle.
    task automatic press(input logic [4:0] m, input int hold);
        rej_cnt = 0;
        val_cnt = 0;
        set_btns(m);
        repeat (hold) tick_sample();
        set_btns(5'b00000);
        repeat (12) tick_sample();
    endtask

    initial begin
        // Reset held: outputs at reset values
        #1 restart_n = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        chk("rst_row", 32'(cursor_row), 0);
        chk("rst_col", 32'(cursor_col), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_valid", 32'(sel_valid), 0);
        chk("rst_reject", 32'(sel_reject), 0);
        restart_n = 1'b1;

        // Idle after reset: nothing asserted
        rej_cnt = 0;
        val_cnt = 0;
        repeat (20) tick_sample();
        chk("idle_quiet", 32'(rej_cnt + val_cnt), 0);

        // Right wrap: 1,2,3,4,0,1
        begin
            int exp_col [6] = '{1, 2, 3, 4, 0, 1};
            for (int i = 0; i < 6; i++) begin
                press(M_RIGHT, 10);
                chk($sformatf("wrap_col%0d", i), 32'(cursor_col), 32'(exp_col[i]));
            end
        end
        chk("wrap_row", 32'(cursor_row), 0);

        // Up at row 0 wraps to row 4
        press(M_UP, 10);
        chk("up_wrap_row", 32'(cursor_row), 4);

        // Move to (2,3)
        press(M_UP, 10);
        press(M_UP, 10);
        press(M_RIGHT, 10);
        press(M_RIGHT, 10);
        chk("pos_row", 32'(cursor_row), 2);
        chk("pos_col", 32'(cursor_col), 3);

        // Accepted select: data 13, valid held until ack
        press(M_SEL, 10);
        chk("sel_data", 32'(data), 13);
        chk("sel_valid", 32'(sel_valid), 1);
        chk("sel_no_rej", 32'(rej_cnt), 0);
        val_cnt = 0;
        repeat (10) tick_sample();
        chk("valid_held10", 32'(val_cnt), 10);
        sel_ack = 1'b1;
        tick_sample();
        sel_ack = 1'b0;
        chk("ack_valid", 32'(sel_valid), 0);
        chk("ack_data", 32'(data), 13);

        // Cleared cell: one-cycle reject, no request
        cleared[13] = 1'b1;
        press(M_SEL, 10);
        chk("clr_rej_cnt", 32'(rej_cnt), 1);
        chk("clr_valid_cnt", 32'(val_cnt), 0);
        cleared = '0;

        // Busy controller: reject, no request
        busy = 1'b1;
        press(M_SEL, 10);
        chk("busy_rej_cnt", 32'(rej_cnt), 1);
        chk("busy_valid", 32'(val_cnt), 0);
        busy = 1'b0;

        // Second select while a request is pending: rejected, data held
        press(M_SEL, 10);
        chk("req_data", 32'(data), 13);
        press(M_RIGHT, 10);
        chk("req_move_col", 32'(cursor_col), 4);
        press(M_SEL, 10);
        chk("req2_rej_cnt", 32'(rej_cnt), 1);
        chk("req2_data", 32'(data), 13);
        chk("req2_valid", 32'(sel_valid), 1);
        sel_ack = 1'b1;
        tick_sample();
        sel_ack = 1'b0;
        chk("ack2_valid", 32'(sel_valid), 0);

        // 3-cycle glitch is filtered
        press(M_RIGHT, 3);
        chk("glitch_col", 32'(cursor_col), 4);

        // 1-cycle dropout during a held press gives a single move
        set_btns(M_RIGHT);
        repeat (10) tick_sample();
        set_btns(5'b00000);
        tick_sample();
        press(M_RIGHT, 10);
        chk("dropout_col", 32'(cursor_col), 0);

        // Up+down cancel
        press(M_UP | M_DOWN, 10);
        chk("updown_row", 32'(cursor_row), 2);

        // Vertical and horizontal together both apply
        press(M_DOWN | M_RIGHT, 10);
        chk("diag_row", 32'(cursor_row), 3);
        chk("diag_col", 32'(cursor_col), 1);
        press(M_LEFT, 10);
        chk("left_col", 32'(cursor_col), 0);

        // Long hold on right from column 0
        press(M_RIGHT, 2 + 4 + 3 * 16);
        chk("hold_col", 32'(cursor_col), 32'(HOLD_COL));

        // Async reset in the middle of a request
        press(M_SEL, 10);
        chk("pre_rst_data", 32'(data), 32'(3 * 5 + HOLD_COL));
        chk("pre_rst_valid", 32'(sel_valid), 1);
        @(negedge clka);
        #2 restart_n = 1'b0;
        #1;
        chk("arst_row", 32'(cursor_row), 0);
        chk("arst_col", 32'(cursor_col), 0);
        chk("arst_data", 32'(data), 0);
        chk("arst_valid", 32'(sel_valid), 0);
        repeat (2) @(posedge clka);
        #1 restart_n = 1'b1;
        rej_cnt = 0;
        val_cnt = 0;
        repeat (20) tick_sample();
        chk("post_rst_quiet", 32'(rej_cnt + val_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
